// File: rtl/pipelined_alu.sv
// Two-stage pipelined ALU. Stage 1 registers the operands. Stage 2 registers
// the executed result, its flags and the caller's tag. A carry register feeds
// ADDC, and a sticky overflow flag accumulates until flags_clr.
module pipelined_alu #(
  parameter int NUMBITS = 16,
  parameter int TAGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic [3:0]         opcode,
  input  logic [TAGBITS-1:0] in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] result,
  output logic               carryout,
  output logic               overflow,
  output logic               zero,
  output logic               negative,
  output logic               illegal,
  output logic [TAGBITS-1:0] out_tag,
  input  logic               flags_clr,
  output logic               sticky_ovf
);

  localparam int SHW = $clog2(NUMBITS);

  logic               s1_valid;
  logic [NUMBITS-1:0] s1_a, s1_b;
  logic [3:0]         s1_op;
  logic [TAGBITS-1:0] s1_tag;
  logic               carry_reg;

  logic               s1_load, s2_load;
  logic [NUMBITS-1:0] ex_res;
  logic [NUMBITS:0]   ex_wide;
  logic               ex_c, ex_o, ex_ill;
  logic [SHW-1:0]     shamt;

  // Stage 2 is free when it is empty or its content leaves this cycle.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign shamt    = s1_b[SHW-1:0];

  // Stage 1 operand capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_a     <= A;
      s1_b     <= B;
      s1_op    <= opcode;
      s1_tag   <= in_tag;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Execute: combinational from the stage 1 registers and carry_reg
  always_comb begin
    ex_res  = '0;
    ex_wide = '0;
    ex_c    = 1'b0;
    ex_o    = 1'b0;
    ex_ill  = 1'b0;
    case (s1_op)
      4'd0: begin
        ex_wide = {1'b0, s1_a} + {1'b0, s1_b};
        ex_res  = ex_wide[NUMBITS-1:0];
        ex_c    = ex_wide[NUMBITS];
      end
      4'd1: begin
        ex_res = s1_a + s1_b;
        ex_o   = (s1_a[NUMBITS-1] == s1_b[NUMBITS-1]) &&
                 (ex_res[NUMBITS-1] != s1_a[NUMBITS-1]);
      end
      4'd2: begin
        // The extra top bit of the difference is the borrow.
        ex_wide = {1'b0, s1_a} - {1'b0, s1_b};
        ex_res  = ex_wide[NUMBITS-1:0];
        ex_c    = ex_wide[NUMBITS];
      end
      4'd3: begin
        ex_res = s1_a - s1_b;
        ex_o   = (s1_a[NUMBITS-1] != s1_b[NUMBITS-1]) &&
                 (ex_res[NUMBITS-1] != s1_a[NUMBITS-1]);
      end
      4'd4:  ex_res = s1_a & s1_b;
      4'd5:  ex_res = s1_a | s1_b;
      4'd6:  ex_res = s1_a ^ s1_b;
      4'd7:  ex_res = s1_a >> 1;
      4'd8:  ex_res = s1_a << shamt;
      4'd9:  ex_res = s1_a >> shamt;
      4'd10: ex_res = NUMBITS'($signed(s1_a) >>> shamt);
      4'd11: ex_res = {{(NUMBITS-1){1'b0}}, (s1_a < s1_b)};
      4'd12: ex_res = {{(NUMBITS-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      4'd13: ex_res = ~s1_a;
      4'd14: begin
        ex_wide = {1'b0, s1_a} + {1'b0, s1_b} + {{NUMBITS{1'b0}}, carry_reg};
        ex_res  = ex_wide[NUMBITS-1:0];
        ex_c    = ex_wide[NUMBITS];
      end
      default: ex_ill = 1'b1;
    endcase
  end

  // Stage 2 output registers; they hold while the consumer stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      illegal   <= 1'b0;
      out_tag   <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      result    <= ex_res;
      carryout  <= ex_c;
      overflow  <= ex_o;
      zero      <= (ex_res == '0);
      negative  <= ex_res[NUMBITS-1];
      illegal   <= ex_ill;
      out_tag   <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Carry register and sticky overflow; a clear wins over the op transferring alongside it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_reg  <= 1'b0;
      sticky_ovf <= 1'b0;
    end else if (flags_clr) begin
      carry_reg  <= 1'b0;
      sticky_ovf <= 1'b0;
    end else if (s2_load) begin
      if (s1_op == 4'd0 || s1_op == 4'd2 || s1_op == 4'd14)
        carry_reg <= ex_c;
      sticky_ovf <= sticky_ovf | ex_o;
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu with an in-order scoreboard of expected results.
module tb_pipelined_alu;

  typedef struct packed {
    logic [15:0] r;
    logic        c, o, z, n, ill;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] A = '0, B = '0;
  logic [3:0]  opcode = '0, in_tag = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] result;
  logic        carryout, overflow, zero, negative, illegal;
  logic [3:0]  out_tag;
  logic        flags_clr = 1'b0, sticky_ovf;

  int   tests = 0, fails = 0;
  exp_t sb[$];
  logic mcarry = 1'b0;

  pipelined_alu #(.NUMBITS(16), .TAGBITS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carryout(carryout), .overflow(overflow), .zero(zero),
    .negative(negative), .illegal(illegal), .out_tag(out_tag),
    .flags_clr(flags_clr), .sticky_ovf(sticky_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic [3:0] tag);
    exp_t e;
    logic [16:0] w;
    logic [3:0] sh;
    e = '0;
    e.tag = tag;
    sh = b[3:0];
    case (op)
      4'd0:  begin w = 17'(a) + 17'(b); e.r = w[15:0]; e.c = w[16]; end
      4'd1:  begin e.r = a + b; e.o = (a[15] == b[15]) && (e.r[15] != a[15]); end
      4'd2:  begin e.r = a - b; e.c = (a < b); end
      4'd3:  begin e.r = a - b; e.o = (a[15] != b[15]) && (e.r[15] != a[15]); end
      4'd4:  e.r = a & b;
      4'd5:  e.r = a | b;
      4'd6:  e.r = a ^ b;
      4'd7:  e.r = {1'b0, a[15:1]};
      4'd8:  e.r = a << sh;
      4'd9:  e.r = a >> sh;
      4'd10: for (int i = 0; i < 16; i++) e.r[i] = (i + sh > 15) ? a[15] : a[i + sh];
      4'd11: e.r = {15'b0, (a < b)};
      4'd12: e.r = {15'b0, ($signed(a) < $signed(b))};
      4'd13: e.r = ~a;
      4'd14: begin w = 17'(a) + 17'(b) + 17'(cin); e.r = w[15:0]; e.c = w[16]; end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.r == 16'h0);
    e.n = e.r[15];
    return e;
  endfunction

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag);
    int   n;
    logic acc;
    in_valid = 1'b1; opcode = op; A = a; B = b; in_tag = tag;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        sb.push_back(model(op, a, b, mcarry, tag));
        if (op == 4'd0 || op == 4'd2 || op == 4'd14) mcarry = sb[$].c;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: pops on each accepted result and checks stall stability
  exp_t snap;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t cur, e;
    cur = '{result, carryout, overflow, zero, negative, illegal, out_tag};
    if (prev_stall && out_valid) check("stall_stable", 32'(cur), 32'(snap));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(cur), 32'hFFFFFFFF);
      end else begin
        e = sb.pop_front();
        check("result", 32'(cur), 32'(e));
      end
    end
    prev_stall = out_valid && !out_ready;
    snap = cur;
  end

  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_sticky", 32'(sticky_ovf), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // ADDU with carry, two-cycle latency, then ADDC consuming the carry
    send(4'd0, 16'hFFFF, 16'h0001, 4'd1);
    check("latency_c1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_c2", 32'(out_valid), 32'd1);
    send(4'd14, 16'h0000, 16'h0000, 4'd2);
    drain();

    // Signed overflow sets the sticky flag; flags_clr clears it
    send(4'd1, 16'h7FFF, 16'h0001, 4'd3);
    drain();
    check("sticky_set", 32'(sticky_ovf), 32'd1);
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    mcarry = 1'b0;
    check("sticky_clr", 32'(sticky_ovf), 32'd0);

    // Shifts, compares and logic back to back
    send(4'd10, 16'h8000, 16'h0004, 4'd4);
    send(4'd8,  16'h0001, 16'h0013, 4'd5);
    send(4'd12, 16'hFFFF, 16'h0001, 4'd6);
    send(4'd11, 16'hFFFF, 16'h0001, 4'd7);
    send(4'd4,  16'hF0F0, 16'h3C3C, 4'd8);
    send(4'd5,  16'hF0F0, 16'h0F01, 4'd9);
    send(4'd7,  16'h8003, 16'h0000, 4'd10);
    send(4'd9,  16'hFFFF, 16'h000F, 4'd11);
    send(4'd13, 16'hFFFF, 16'h0000, 4'd12);
    drain();

    // Five ops into a stalled consumer
    out_ready = 1'b0;
    fork
      begin
        send(4'd0, 16'h0001, 16'h0002, 4'd0);
        send(4'd3, 16'h8000, 16'h0001, 4'd1);
        send(4'd6, 16'hAAAA, 16'hFFFF, 4'd2);
        send(4'd9, 16'h8000, 16'h000F, 4'd3);
        send(4'd13, 16'h1234, 16'h0000, 4'd4);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal opcode and borrow
    send(4'd15, 16'h0005, 16'h0005, 4'd13);
    send(4'd2,  16'h0003, 16'h0005, 4'd14);
    drain();

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(4'd1, 16'h7FFF, 16'h0001, 4'd5);
    send(4'd4, 16'h00FF, 16'h0F0F, 4'd6);
    check("pre_rst_sticky", 32'(sticky_ovf), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sticky", 32'(sticky_ovf), 32'd0);
    sb.delete();
    mcarry = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_output", 32'(out_valid), 32'd0);

    // Carry register was cleared by reset
    send(4'd14, 16'h0000, 16'h0000, 4'd15);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
